// File: rtl/addr_pkg.sv
// Shared definitions for the addressed register bus.
// - addr_dir_t : transfer direction, also decoded by the bus targets.
// - ADDR_W_DEF / DATA_W_DEF : default address and data widths of the bus.
package addr_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    READ         = 2'b00,
    WRITE        = 2'b01,
    READ_N_WRITE = 2'b10
  } addr_dir_t;

endpackage

// File: rtl/addr_bus_master.sv
// Initiator for the addressed register bus. Accepts one command at a time, broadcasts it as a
// single-cycle read or write enable pulse with the address and write data, waits READ_LATENCY
// cycles for read data, then returns the result on a valid/ready response channel.
//
// Ports
// - clk, rst_n                    : clock, asynchronous active-low reset
// - cmd_valid/cmd_ready           : command handshake (ready only while idle)
// - cmd_addr/cmd_write/cmd_wdata  : command payload
// - rsp_valid/rsp_ready           : response handshake
// - rsp_rdata/rsp_write           : read data (0 for writes), direction echo
// - bus_active_address            : broadcast address, IDLE_ADDR when no transfer is in flight
// - bus_read_enable/bus_write_enable : one-cycle enable pulses, never both high
// - bus_wdata                     : broadcast write data
// - bus_rdata                     : read data from the addressed target
module addr_bus_master
  import addr_pkg::*;
#(
  parameter int unsigned       ADDR_W       = ADDR_W_DEF,
  parameter int unsigned       DATA_W       = DATA_W_DEF,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [ADDR_W-1:0] IDLE_ADDR    = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] bus_active_address,
  output logic              bus_read_enable,
  output logic              bus_write_enable,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int unsigned CNT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  addr_dir_t         dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_write_q, rsp_write_d;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    // Enables are pulses: they are only ever raised on the transition into StIssue.
    re_d        = 1'b0;
    we_d        = 1'b0;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_write_d = rsp_write_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d     = StIssue;
          dir_d       = cmd_write ? WRITE : READ;
          addr_d      = cmd_addr;
          wdata_d     = cmd_write ? cmd_wdata : '0;
          we_d        = cmd_write;
          re_d        = ~cmd_write;
          cmd_ready_d = 1'b0;
        end
      end

      StIssue: begin
        if (dir_q == WRITE) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
        end else if (READ_LATENCY == 0) begin
          // Zero-latency targets answer combinationally during the pulse.
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_rdata;
          rsp_write_d = 1'b0;
        end else begin
          state_d = StWait;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
        end
      end

      StWait: begin
        if (cnt_q == '0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_rdata;
          rsp_write_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          addr_d      = IDLE_ADDR;
          wdata_d     = '0;
        end
      end

      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        addr_d      = IDLE_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dir_q       <= READ;
      cnt_q       <= '0;
      addr_q      <= IDLE_ADDR;
      wdata_q     <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      re_q        <= re_d;
      we_q        <= we_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_write          = rsp_write_q;
  assign bus_active_address = addr_q;
  assign bus_read_enable    = re_q;
  assign bus_write_enable   = we_q;
  assign bus_wdata          = wdata_q;

  // Bus protocol invariants.
  a_one_hot_enable : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus_read_enable && bus_write_enable));
  a_pulse_in_issue : assert property (@(posedge clk) disable iff (!rst_n)
    (bus_read_enable || bus_write_enable) |-> (state_q == StIssue));
  a_ready_in_idle : assert property (@(posedge clk) disable iff (!rst_n)
    cmd_ready |-> (state_q == StIdle));

endmodule

// File: tb/tb_addr_bus_master.sv
module tb_addr_bus_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] cmd_valid = '0;
  logic [2:0] cmd_ready;
  logic [3:0] cmd_addr = '0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic [2:0] rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata [3];
  logic [2:0] rsp_write;
  logic [3:0] bus_addr [3];
  logic [2:0] bus_re;
  logic [2:0] bus_we;
  logic [7:0] bus_wdata [3];
  logic [7:0] bus_rdata [3];

  int checks = 0;
  int errors = 0;

  // Instance 0: READ_LATENCY 1, instance 1: 0, instance 2: 4. Each has targets at 3 and 5.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 0 : 4);
    logic [7:0] t3_q, t5_q, rd_c;
    logic [7:0] pipe [1:4];
    int wr_n, rd_n, t3_wr_n, t5_wr_n, both_n;
    logic sel3, sel5;

    assign sel3 = (bus_addr[g] == 4'd3);
    assign sel5 = (bus_addr[g] == 4'd5);

    addr_bus_master #(
      .ADDR_W      (4),
      .DATA_W      (8),
      .READ_LATENCY(Lat),
      .IDLE_ADDR   (4'hF)
    ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cmd_valid         (cmd_valid[g]),
      .cmd_ready         (cmd_ready[g]),
      .cmd_addr          (cmd_addr),
      .cmd_write         (cmd_write),
      .cmd_wdata         (cmd_wdata),
      .rsp_valid         (rsp_valid[g]),
      .rsp_ready         (rsp_ready),
      .rsp_rdata         (rsp_rdata[g]),
      .rsp_write         (rsp_write[g]),
      .bus_active_address(bus_addr[g]),
      .bus_read_enable   (bus_re[g]),
      .bus_write_enable  (bus_we[g]),
      .bus_wdata         (bus_wdata[g]),
      .bus_rdata         (bus_rdata[g])
    );

    always_comb begin
      rd_c = 8'h00;
      if (bus_re[g] && sel3) rd_c = t3_q;
      else if (bus_re[g] && sel5) rd_c = t5_q;
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        t3_q <= 8'h00;
        t5_q <= 8'h3C;
      end else begin
        if (bus_we[g] && sel3) t3_q <= bus_wdata[g];
        if (bus_we[g] && sel5) t5_q <= bus_wdata[g];
      end
    end

    always @(posedge clk) begin
      pipe[1] <= rd_c;
      for (int k = 2; k <= 4; k++) pipe[k] <= pipe[k-1];
    end

    assign bus_rdata[g] = (Lat == 0) ? rd_c : pipe[(Lat == 0) ? 1 : Lat];

    always @(posedge clk) begin
      if (clr) begin
        wr_n <= 0; rd_n <= 0; t3_wr_n <= 0; t5_wr_n <= 0; both_n <= 0;
      end else begin
        wr_n    <= wr_n + int'(bus_we[g]);
        rd_n    <= rd_n + int'(bus_re[g]);
        t3_wr_n <= t3_wr_n + int'(bus_we[g] && sel3);
        t5_wr_n <= t5_wr_n + int'(bus_we[g] && sel5);
        both_n  <= both_n + int'(bus_we[g] && bus_re[g]);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // One full transaction on instance i with rsp_ready high; checks the cycle-exact timeline.
  task automatic run_cmd(input int i, input logic [3:0] a, input logic w, input logic [7:0] wd,
                         input int lat, input logic [7:0] exp_rd);
    int n;
    n = w ? 2 : 2 + lat;
    @(negedge clk);
    check_eq("idle_cmd_ready", cmd_ready[i], 1);
    cmd_valid[i] = 1'b1;
    cmd_addr     = a;
    cmd_write    = w;
    cmd_wdata    = wd;
    @(negedge clk);
    cmd_valid[i] = 1'b0;
    check_eq("issue_we", bus_we[i], w);
    check_eq("issue_re", bus_re[i], !w);
    check_eq("issue_addr", bus_addr[i], a);
    check_eq("issue_busy", cmd_ready[i], 0);
    if (w) check_eq("issue_wdata", bus_wdata[i], wd);
    for (int k = 2; k < n; k++) begin
      @(negedge clk);
      check_eq("wait_no_rsp", rsp_valid[i], 0);
      check_eq("wait_no_en", bus_we[i] | bus_re[i], 0);
      check_eq("wait_addr", bus_addr[i], a);
    end
    @(negedge clk);
    check_eq("rsp_valid", rsp_valid[i], 1);
    check_eq("rsp_write", rsp_write[i], w);
    check_eq("rsp_rdata", rsp_rdata[i], exp_rd);
    @(negedge clk);
    check_eq("post_rsp_valid", rsp_valid[i], 0);
    check_eq("post_idle_addr", bus_addr[i], 4'hF);
    check_eq("post_cmd_ready", cmd_ready[i], 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // Reset state
    check_eq("rst_cmd_ready", cmd_ready[0], 1);
    check_eq("rst_rsp_valid", rsp_valid[0], 0);
    check_eq("rst_rsp_rdata", rsp_rdata[0], 0);
    check_eq("rst_rsp_write", rsp_write[0], 0);
    check_eq("rst_en", bus_we[0] | bus_re[0], 0);
    check_eq("rst_addr", bus_addr[0], 4'hF);
    check_eq("rst_wdata", bus_wdata[0], 0);
    rst_n = 1'b1;
    clr   = 1'b0;

    // Write A5 to target 3, then read 3C from target 5 (latency 1)
    clear_counts();
    run_cmd(0, 4'd3, 1'b1, 8'hA5, 1, 8'h00);
    check_eq("w3_pulses", g_inst[0].wr_n, 1);
    check_eq("w3_t3_en", g_inst[0].t3_wr_n, 1);
    check_eq("w3_t5_en", g_inst[0].t5_wr_n, 0);
    check_eq("w3_t3_val", g_inst[0].t3_q, 8'hA5);
    run_cmd(0, 4'd5, 1'b0, 8'h00, 1, 8'h3C);
    check_eq("r5_pulses", g_inst[0].rd_n, 1);

    // Latency 0 and 4 builds
    run_cmd(1, 4'd5, 1'b0, 8'h00, 0, 8'h3C);
    run_cmd(1, 4'd3, 1'b1, 8'h5A, 0, 8'h00);
    run_cmd(1, 4'd3, 1'b0, 8'h00, 0, 8'h5A);
    run_cmd(2, 4'd5, 1'b0, 8'h00, 4, 8'h3C);
    run_cmd(2, 4'd3, 1'b1, 8'hC3, 4, 8'h00);
    run_cmd(2, 4'd3, 1'b0, 8'h00, 4, 8'hC3);

    // Back-pressure: response held for 10 cycles with the next command pending
    clear_counts();
    @(negedge clk);
    rsp_ready    = 1'b0;
    cmd_valid[0] = 1'b1;
    cmd_addr     = 4'd5;
    cmd_write    = 1'b1;
    cmd_wdata    = 8'h11;
    @(negedge clk);
    cmd_addr  = 4'd3;
    cmd_write = 1'b0;
    cmd_wdata = 8'h00;
    @(negedge clk);
    check_eq("stall_rsp_first", rsp_valid[0], 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("stall_ready", cmd_ready[0], 0);
      check_eq("stall_valid", rsp_valid[0], 1);
      check_eq("stall_write", rsp_write[0], 1);
      check_eq("stall_rdata", rsp_rdata[0], 0);
      check_eq("stall_no_en", bus_we[0] | bus_re[0], 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("ack_rsp_valid", rsp_valid[0], 0);
    check_eq("ack_cmd_ready", cmd_ready[0], 1);
    check_eq("ack_wr_pulses", g_inst[0].wr_n, 1);
    check_eq("ack_rd_pulses", g_inst[0].rd_n, 0);
    check_eq("ack_t5_val", g_inst[0].t5_q, 8'h11);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    check_eq("next_re", bus_re[0], 1);
    check_eq("next_addr", bus_addr[0], 4'd3);
    @(negedge clk);
    check_eq("next_wait", rsp_valid[0], 0);
    @(negedge clk);
    check_eq("next_rsp_valid", rsp_valid[0], 1);
    check_eq("next_rsp_rdata", rsp_rdata[0], 8'hA5);
    check_eq("next_rsp_write", rsp_write[0], 0);
    @(negedge clk);

    // Unmapped write
    clear_counts();
    run_cmd(0, 4'd7, 1'b1, 8'h99, 1, 8'h00);
    check_eq("w7_pulses", g_inst[0].wr_n, 1);
    check_eq("w7_t3_en", g_inst[0].t3_wr_n, 0);
    check_eq("w7_t5_en", g_inst[0].t5_wr_n, 0);

    // Reset with instance 2 in WAIT and instance 0 in ISSUE
    @(negedge clk);
    cmd_valid[2] = 1'b1;
    cmd_addr     = 4'd3;
    cmd_write    = 1'b0;
    @(negedge clk);
    cmd_valid[2] = 1'b0;
    cmd_valid[0] = 1'b1;
    cmd_addr     = 4'd5;
    cmd_write    = 1'b1;
    cmd_wdata    = 8'h77;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    check_eq("pre_rst_we0", bus_we[0], 1);
    check_eq("pre_rst_addr2", bus_addr[2], 4'd3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_we0", bus_we[0], 0);
    check_eq("rst_re2", bus_re[2], 0);
    check_eq("rst_addr0", bus_addr[0], 4'hF);
    check_eq("rst_addr2", bus_addr[2], 4'hF);
    check_eq("rst_rsp_v", {29'd0, rsp_valid}, 0);
    check_eq("rst_ready", {29'd0, cmd_ready}, 3'b111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("no_stale_rsp", {29'd0, rsp_valid}, 0);
    end
    run_cmd(2, 4'd5, 1'b0, 8'h00, 4, 8'h3C);

    check_eq("never_both0", g_inst[0].both_n, 0);
    check_eq("never_both1", g_inst[1].both_n, 0);
    check_eq("never_both2", g_inst[2].both_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
